// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download arbiter.
// Covers the FSM state set, the read pipeline depth and the captured-write record.
package rom_dl_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    DRAIN,
    HOLD
  } dlState_e;

  localparam int RD_LAT = 2;

  // Width of the raw ioctl address bus.
  localparam int DL_ADDR_W = 25;

  typedef struct packed {
    logic [DL_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } wrRec_t;

  // True when an ioctl address fits inside a memory of 2^addrW bytes.
  function automatic logic addrInRange(input logic [DL_ADDR_W-1:0] addr, input int addrW);
    return (addr >> addrW) == '0;
  endfunction

endpackage

// File: rtl/rom_dl_wport.sv
// Pending download write slot: holds one captured byte until the arbiter commits it,
// and counts how many cycles it has been deferred by core reads.
module rom_dl_wport
  import rom_dl_pkg::*;
#(
  parameter int MAX_DEFER = 4
) (
  input  logic   Clk_I,
  input  logic   Reset_n,
  input  logic   capture_i,
  input  wrRec_t rec_i,
  input  logic   grant_i,
  output logic   req_o,
  output logic   force_o,
  output logic   commit_o,
  output wrRec_t rec_o
);

  localparam int DW = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

  logic          pending_q, pending_d;
  wrRec_t        rec_q, rec_d;
  logic [DW-1:0] defer_q, defer_d;

  assign req_o    = pending_q;
  assign force_o  = pending_q && (defer_q == DW'(MAX_DEFER));
  assign commit_o = pending_q && grant_i;
  assign rec_o    = rec_q;

  // A pending write that is not granted this cycle lost to a core read.
  always_comb begin
    pending_d = pending_q;
    rec_d     = rec_q;
    defer_d   = defer_q;
    if (commit_o) begin
      pending_d = 1'b0;
      defer_d   = '0;
    end else if (pending_q) begin
      defer_d = defer_q + DW'(1);
    end
    if (capture_i) begin
      pending_d = 1'b1;
      rec_d     = rec_i;
      defer_d   = '0;
    end
  end

  always_ff @(posedge Clk_I or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_q <= 1'b0;
      rec_q     <= '0;
      defer_q   <= '0;
    end else begin
      pending_q <= pending_d;
      rec_q     <= rec_d;
      defer_q   <= defer_d;
    end
  end

endmodule

// File: rtl/rom_dl_arbiter.sv
// Shares the single-port game memory between the HPS ioctl downloader and the core,
// and holds the core in reset while a download is loading and for a while after.
module rom_dl_arbiter
  import rom_dl_pkg::*;
#(
  parameter int         ADDR_W      = 14,
  parameter logic [7:0] ROM_INDEX   = 8'd0,
  parameter int         HOLD_CYCLES = 16,
  parameter int         MAX_DEFER   = 4
) (
  input  logic              Clk_I,
  input  logic              Reset_n,
  input  logic              Dl_Active_I,
  input  logic [7:0]        Dl_Index_I,
  input  logic              Dl_Wr_I,
  input  logic [24:0]       Dl_Addr_I,
  input  logic [7:0]        Dl_Data_I,
  output logic              Dl_Wait_O,
  input  logic              Core_Rd_I,
  input  logic [ADDR_W-1:0] Core_Addr_I,
  output logic [7:0]        Core_Data_O,
  output logic              Core_Valid_O,
  output logic [ADDR_W-1:0] Ram_Addr_O,
  output logic [7:0]        Ram_Data_O,
  output logic              Ram_We_O,
  input  logic [7:0]        Ram_Data_I,
  output logic              Core_Reset_n_O,
  output logic [24:0]       Bytes_O,
  output logic [7:0]        Checksum_O,
  output logic              Err_O
);

  localparam int HCW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  dlState_e        state_q;
  logic [HCW-1:0]  holdCnt_q;
  logic            coreRstN_q;
  logic [24:0]     bytes_q;
  logic [7:0]      checksum_q;
  logic            err_q;
  logic            dlActive_q;
  logic [RD_LAT-1:0] rdPipe_q;
  logic [7:0]      coreData_q;

  logic   wpReq, wpForce, wpCommit, wpGrant;
  wrRec_t capRec, wpRec;
  logic   inRange, idxMatch, dlRise, capture, errSet, rdGranted;
  logic   unusedAddrHi;

  assign inRange  = addrInRange(Dl_Addr_I, ADDR_W);
  assign idxMatch = (Dl_Index_I == ROM_INDEX);
  assign dlRise   = Dl_Active_I && !dlActive_q;
  assign capture  = (state_q == LOAD) && Dl_Wr_I && !wpReq && inRange;
  assign errSet   = (state_q == LOAD) && Dl_Wr_I && (wpReq || !inRange);

  assign capRec.addr = Dl_Addr_I;
  assign capRec.data = Dl_Data_I;

  // Core reads normally win; a write deferred MAX_DEFER times takes the slot and the read is dropped.
  assign wpGrant   = wpReq && (!Core_Rd_I || wpForce);
  assign rdGranted = Core_Rd_I && !wpGrant;

  rom_dl_wport #(
    .MAX_DEFER (MAX_DEFER)
  ) uWport (
    .Clk_I     (Clk_I),
    .Reset_n   (Reset_n),
    .capture_i (capture),
    .rec_i     (capRec),
    .grant_i   (wpGrant),
    .req_o     (wpReq),
    .force_o   (wpForce),
    .commit_o  (wpCommit),
    .rec_o     (wpRec)
  );

  // Captured addresses are always in range, so the upper record bits carry nothing.
  assign unusedAddrHi = ^wpRec.addr[DL_ADDR_W-1:ADDR_W];

  always_comb begin
    Ram_Addr_O = wpRec.addr[ADDR_W-1:0];
    Ram_Data_O = wpRec.data;
    Ram_We_O   = wpGrant;
    if (rdGranted) begin
      Ram_Addr_O = Core_Addr_I;
    end
  end

  always_ff @(posedge Clk_I or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= HOLD;
      holdCnt_q  <= '0;
      coreRstN_q <= 1'b0;
      bytes_q    <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
      dlActive_q <= 1'b0;
    end else begin
      dlActive_q <= Dl_Active_I;
      if (wpCommit) begin
        bytes_q    <= bytes_q + 25'd1;
        checksum_q <= checksum_q + wpRec.data;
      end
      if (errSet) begin
        err_q <= 1'b1;
      end
      // Entering LOAD clears the statistics; that clear overrides a same-cycle commit.
      case (state_q)
        RUN: begin
          coreRstN_q <= 1'b1;
          if (Dl_Active_I && idxMatch) begin
            state_q    <= LOAD;
            coreRstN_q <= 1'b0;
            bytes_q    <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
          end
        end
        LOAD: begin
          if (!Dl_Active_I) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (dlRise && idxMatch) begin
            state_q    <= LOAD;
            bytes_q    <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
          end else if (!wpReq) begin
            state_q   <= HOLD;
            holdCnt_q <= '0;
          end
        end
        HOLD: begin
          if (dlRise && idxMatch) begin
            state_q    <= LOAD;
            bytes_q    <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
          end else if (holdCnt_q == HCW'(HOLD_CYCLES - 1)) begin
            state_q    <= RUN;
            coreRstN_q <= 1'b1;
          end else begin
            holdCnt_q <= holdCnt_q + HCW'(1);
          end
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  // Stage 0 marks a read whose address reached the memory; its data lands one cycle later.
  always_ff @(posedge Clk_I or negedge Reset_n) begin
    if (!Reset_n) begin
      rdPipe_q   <= '0;
      coreData_q <= '0;
    end else begin
      rdPipe_q <= {rdPipe_q[RD_LAT-2:0], rdGranted};
      if (rdPipe_q[RD_LAT-2]) begin
        coreData_q <= Ram_Data_I;
      end
    end
  end

  assign Dl_Wait_O      = wpReq;
  assign Core_Valid_O   = rdPipe_q[RD_LAT-1];
  assign Core_Data_O    = coreData_q;
  assign Core_Reset_n_O = coreRstN_q;
  assign Bytes_O        = bytes_q;
  assign Checksum_O     = checksum_q;
  assign Err_O          = err_q;

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Directed bench for rom_dl_arbiter with a registered 1-cycle memory model.
module tb_rom_dl_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        dlActive, dlWr;
  logic [7:0]  dlIndex, dlData;
  logic [24:0] dlAddr;
  logic        dlWait;
  logic        coreRd;
  logic [13:0] coreAddr;
  logic [7:0]  coreData;
  logic        coreValid;
  logic [13:0] ramAddr;
  logic [7:0]  ramDataO;
  logic        ramWe;
  logic [7:0]  ramDataI;
  logic        coreRstN;
  logic [24:0] bytes;
  logic [7:0]  checksum;
  logic        err;

  int errors = 0;
  int checks = 0;
  int stepIdx = -1;

  logic [7:0]  mem [0:16383];
  bit          memReady;
  logic [13:0] wrAddrQ [$];
  logic [7:0]  wrDataQ [$];
  int          wrStepQ [$];
  bit          rstSeenHigh;

  rom_dl_arbiter dut (
    .Clk_I          (clk),
    .Reset_n        (rstN),
    .Dl_Active_I    (dlActive),
    .Dl_Index_I     (dlIndex),
    .Dl_Wr_I        (dlWr),
    .Dl_Addr_I      (dlAddr),
    .Dl_Data_I      (dlData),
    .Dl_Wait_O      (dlWait),
    .Core_Rd_I      (coreRd),
    .Core_Addr_I    (coreAddr),
    .Core_Data_O    (coreData),
    .Core_Valid_O   (coreValid),
    .Ram_Addr_O     (ramAddr),
    .Ram_Data_O     (ramDataO),
    .Ram_We_O       (ramWe),
    .Ram_Data_I     (ramDataI),
    .Core_Reset_n_O (coreRstN),
    .Bytes_O        (bytes),
    .Checksum_O     (checksum),
    .Err_O          (err)
  );

  always #5 clk = ~clk;

  // Memory model plus write/reset-level logging, sampled on the pre-edge values.
  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 8; i++) mem[14'h100 + 14'(i)] <= 8'h30 + 8'(7 * i);
      memReady <= 1'b1;
    end
    if (ramWe === 1'b1) begin
      mem[ramAddr] <= ramDataO;
      wrAddrQ.push_back(ramAddr);
      wrDataQ.push_back(ramDataO);
      wrStepQ.push_back(stepIdx);
    end
    ramDataI <= mem[ramAddr];
    if (coreRstN === 1'b1) rstSeenHigh = 1'b1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Returns the posedge index (1-based) at which the core reset first reads high, 0 on timeout.
  task automatic waitCoreRun(output int edges);
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (coreRstN === 1'b1) begin
        edges = k;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic startDownload(input logic [7:0] idx);
    dlActive = 1'b1;
    dlIndex  = idx;
    @(negedge clk);
  endtask

  task automatic sendByte(input logic [24:0] a, input logic [7:0] d, output int waitCyc);
    dlWr = 1'b1; dlAddr = a; dlData = d;
    @(negedge clk);
    dlWr = 1'b0;
    waitCyc = 0;
    while (dlWait === 1'b1 && waitCyc < 20) begin
      waitCyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int e;
    rstN = 1'b0; dlActive = 1'b0; dlIndex = 8'd0; dlWr = 1'b0; dlAddr = '0; dlData = '0;
    coreRd = 1'b0; coreAddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (coreRstN !== 1'b0) begin errors++; $display("[TB] FAIL rst_core_reset: got %b expected 0", coreRstN); end
    checks++; if (dlWait !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait: got %b expected 0", dlWait); end
    checks++; if (ramWe !== 1'b0) begin errors++; $display("[TB] FAIL rst_we: got %b expected 0", ramWe); end
    checks++; if (coreValid !== 1'b0 || coreData !== 8'h00) begin errors++; $display("[TB] FAIL rst_read: got valid=%b data=%h expected 0/00", coreValid, coreData); end
    checks++; if (bytes !== 25'd0 || checksum !== 8'h00 || err !== 1'b0) begin errors++; $display("[TB] FAIL rst_stats: got bytes=%0d sum=%h err=%b expected 0/00/0", bytes, checksum, err); end
    rstN = 1'b1;
    waitCoreRun(e);
    checks++; if (e !== 16) begin errors++; $display("[TB] FAIL rst_hold_len: got %0d expected 16", e); end
  endtask

  task automatic test_download;
    int wc, base, e;
    startDownload(8'd0);
    checks++; if (coreRstN !== 1'b0) begin errors++; $display("[TB] FAIL load_core_reset: got %b expected 0", coreRstN); end
    rstSeenHigh = 1'b0;
    base = wrAddrQ.size();
    for (int i = 0; i < 4; i++) begin
      sendByte(25'(i), 8'(i + 1), wc);
      checks++; if (wc !== 1) begin errors++; $display("[TB] FAIL dl_wait_len%0d: got %0d expected 1", i, wc); end
    end
    checks++; if (wrAddrQ.size() - base !== 4) begin errors++; $display("[TB] FAIL dl_write_count: got %0d expected 4", wrAddrQ.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wrAddrQ[base + i] !== 14'(i) || wrDataQ[base + i] !== 8'(i + 1)) begin
          errors++; $display("[TB] FAIL dl_write%0d: got addr=%h data=%h expected %h/%h", i, wrAddrQ[base + i], wrDataQ[base + i], 14'(i), 8'(i + 1));
        end
      end
    end
    checks++; if (bytes !== 25'd4) begin errors++; $display("[TB] FAIL dl_bytes: got %0d expected 4", bytes); end
    checks++; if (checksum !== 8'h0A) begin errors++; $display("[TB] FAIL dl_checksum: got %h expected 0a", checksum); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL dl_err: got %b expected 0", err); end
    dlActive = 1'b0;
    waitCoreRun(e);
    checks++; if (rstSeenHigh !== 1'b0) begin errors++; $display("[TB] FAIL dl_core_held: got %b expected 0", rstSeenHigh); end
    // One edge leaves LOAD, one leaves DRAIN, then HOLD lasts 16 cycles.
    checks++; if (e !== 18) begin errors++; $display("[TB] FAIL dl_release_len: got %0d expected 18", e); end
  endtask

  task automatic test_starvation;
    int base;
    logic       obsV [0:10];
    logic [7:0] obsD [0:10];
    logic [7:0] expD;
    startDownload(8'd0);
    base = wrAddrQ.size();
    dlWr = 1'b1; dlAddr = 25'h10; dlData = 8'h5A;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      dlWr = 1'b0;
      obsV[j] = coreValid;
      obsD[j] = coreData;
      stepIdx = j;
      coreRd = (j < 8);
      coreAddr = 14'h100 + 14'(j);
    end
    stepIdx = -1;
    coreRd = 1'b0;
    checks++; if (wrAddrQ.size() - base !== 1) begin errors++; $display("[TB] FAIL starve_write_count: got %0d expected 1", wrAddrQ.size() - base); end
    else begin
      checks++; if (wrStepQ[base] !== 4) begin errors++; $display("[TB] FAIL starve_commit_cycle: got %0d expected 4", wrStepQ[base]); end
      checks++; if (wrAddrQ[base] !== 14'h10 || wrDataQ[base] !== 8'h5A) begin errors++; $display("[TB] FAIL starve_write: got %h/%h expected 0010/5a", wrAddrQ[base], wrDataQ[base]); end
    end
    for (int i = 0; i < 8; i++) begin
      expD = 8'h30 + 8'(7 * i);
      checks++;
      if (i == 4) begin
        if (obsV[i + 2] !== 1'b0) begin errors++; $display("[TB] FAIL starve_lost_read: got valid=%b expected 0", obsV[i + 2]); end
      end else if (obsV[i + 2] !== 1'b1 || obsD[i + 2] !== expD) begin
        errors++; $display("[TB] FAIL starve_read%0d: got valid=%b data=%h expected 1/%h", i, obsV[i + 2], obsD[i + 2], expD);
      end
    end
    checks++; if (obsV[0] !== 1'b0 || obsV[1] !== 1'b0 || obsV[10] !== 1'b0) begin errors++; $display("[TB] FAIL starve_idle_valid: got %b%b%b expected 000", obsV[0], obsV[1], obsV[10]); end
    checks++; if (bytes !== 25'd1 || checksum !== 8'h5A) begin errors++; $display("[TB] FAIL starve_stats: got %0d/%h expected 1/5a", bytes, checksum); end
  endtask

  task automatic test_out_of_range;
    int wc, base, e;
    base = wrAddrQ.size();
    sendByte(25'h4000, 8'hEE, wc);
    checks++; if (wc !== 0) begin errors++; $display("[TB] FAIL oor_wait: got %0d expected 0", wc); end
    repeat (3) @(negedge clk);
    checks++; if (wrAddrQ.size() - base !== 0) begin errors++; $display("[TB] FAIL oor_no_write: got %0d expected 0", wrAddrQ.size() - base); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL oor_err: got %b expected 1", err); end
    checks++; if (bytes !== 25'd1) begin errors++; $display("[TB] FAIL oor_bytes: got %0d expected 1", bytes); end
    dlActive = 1'b0;
    waitCoreRun(e);
    checks++; if (e !== 18) begin errors++; $display("[TB] FAIL oor_release_len: got %0d expected 18", e); end
  endtask

  task automatic test_back_to_back;
    int base, e;
    startDownload(8'd0);
    checks++; if (err !== 1'b0 || bytes !== 25'd0) begin errors++; $display("[TB] FAIL b2b_entry_clear: got err=%b bytes=%0d expected 0/0", err, bytes); end
    base = wrAddrQ.size();
    dlWr = 1'b1; dlAddr = 25'h20; dlData = 8'h11;
    @(negedge clk);
    dlAddr = 25'h21; dlData = 8'h22;
    @(negedge clk);
    dlWr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wrAddrQ.size() - base !== 1) begin errors++; $display("[TB] FAIL b2b_write_count: got %0d expected 1", wrAddrQ.size() - base); end
    else begin
      checks++; if (wrAddrQ[base] !== 14'h20 || wrDataQ[base] !== 8'h11) begin errors++; $display("[TB] FAIL b2b_write: got %h/%h expected 0020/11", wrAddrQ[base], wrDataQ[base]); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL b2b_err: got %b expected 1", err); end
    checks++; if (bytes !== 25'd1 || checksum !== 8'h11) begin errors++; $display("[TB] FAIL b2b_stats: got %0d/%h expected 1/11", bytes, checksum); end
    dlActive = 1'b0;
    waitCoreRun(e);
    checks++; if (e === 0) begin errors++; $display("[TB] FAIL b2b_release: got timeout expected release"); end
  endtask

  task automatic test_wrong_index;
    int base;
    bit lowSeen;
    lowSeen = 1'b0;
    base = wrAddrQ.size();
    dlActive = 1'b1; dlIndex = 8'd1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (coreRstN !== 1'b1) lowSeen = 1'b1;
      dlWr = (j % 2 == 0);
      dlAddr = 25'h40 + 25'(j);
      dlData = 8'h70 + 8'(j);
    end
    dlActive = 1'b0; dlWr = 1'b0; dlIndex = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (lowSeen !== 1'b0) begin errors++; $display("[TB] FAIL idx_core_reset: got low expected high"); end
    checks++; if (wrAddrQ.size() - base !== 0) begin errors++; $display("[TB] FAIL idx_no_write: got %0d expected 0", wrAddrQ.size() - base); end
    checks++; if (err !== 1'b1 || bytes !== 25'd1) begin errors++; $display("[TB] FAIL idx_stats_kept: got err=%b bytes=%0d expected 1/1", err, bytes); end
  endtask

  task automatic test_reset_mid;
    int wc, base, e;
    startDownload(8'd0);
    sendByte(25'h30, 8'h44, wc);
    checks++; if (bytes !== 25'd1) begin errors++; $display("[TB] FAIL mid_pre_bytes: got %0d expected 1", bytes); end
    base = wrAddrQ.size();
    dlWr = 1'b1; dlAddr = 25'h31; dlData = 8'h55;
    @(negedge clk);
    dlWr = 1'b0;
    checks++; if (dlWait !== 1'b1) begin errors++; $display("[TB] FAIL mid_wait: got %b expected 1", dlWait); end
    #2 rstN = 1'b0;
    #1;
    checks++; if (dlWait !== 1'b0 || ramWe !== 1'b0) begin errors++; $display("[TB] FAIL mid_pending_drop: got wait=%b we=%b expected 0/0", dlWait, ramWe); end
    checks++; if (bytes !== 25'd0 || checksum !== 8'h00 || err !== 1'b0) begin errors++; $display("[TB] FAIL mid_stats: got %0d/%h/%b expected 0/00/0", bytes, checksum, err); end
    checks++; if (coreRstN !== 1'b0) begin errors++; $display("[TB] FAIL mid_core_reset: got %b expected 0", coreRstN); end
    repeat (2) @(negedge clk);
    dlActive = 1'b0;
    rstN = 1'b1;
    checks++; if (wrAddrQ.size() - base !== 0) begin errors++; $display("[TB] FAIL mid_no_write: got %0d expected 0", wrAddrQ.size() - base); end
    waitCoreRun(e);
    checks++; if (e !== 16) begin errors++; $display("[TB] FAIL mid_hold_len: got %0d expected 16", e); end
  endtask

  initial begin
    test_reset();
    test_download();
    test_starvation();
    test_out_of_range();
    test_back_to_back();
    test_wrong_index();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
